// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver state encoding and a
// majority-vote helper used by the bit sampler.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake and status bundle between uart_rx_cfg and its consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_busy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data_out, rx_valid, rx_busy, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out, rx_valid, rx_busy, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// Baud counter with 3-point majority sampler around mid-bit; decision strobes at MID+1,
// bit_end marks the last count of the bit before the counter wraps to 0.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic soft_rst,
  input  logic start,
  input  logic clr,
  input  logic run,
  input  logic line,
  output logic bit_value,
  output logic bit_strobe,
  output logic bit_end
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_LO  = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID = CW'(MID);
  localparam logic [CW-1:0] C_HI  = CW'(MID + 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic          s_lo;
  logic          s_mid;

  // start loads 1 because the edge-detect cycle itself is count 0 of the start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      s_lo  <= 1'b0;
      s_mid <= 1'b0;
    end else if (soft_rst) begin
      cnt   <= '0;
      s_lo  <= 1'b0;
      s_mid <= 1'b0;
    end else begin
      if (start)
        cnt <= CW'(1);
      else if (clr)
        cnt <= '0;
      else if (run)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == C_LO)
        s_lo <= line;
      if (cnt == C_MID)
        s_mid <= line;
    end
  end

  assign bit_value  = maj3(s_lo, s_mid, line);
  assign bit_strobe = run && (cnt == C_HI);
  assign bit_end    = run && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line, majority-sampled bits, optional parity,
// 1 or 2 stop bits, valid/ready output holding register with overrun detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_rst,
  input  logic          rx_in,
  uart_rx_cfg_if.master rx_if
);
  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_t            state, state_nxt;
  logic [1:0]           sync;
  logic                 rx_s, rx_prev;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 par_flag;
  logic                 exp_par;

  logic                 bit_value, bit_strobe, bit_end;
  logic                 smp_start, smp_clr, smp_run;
  logic                 shift_en, par_chk, stop_adv, word_done, frame_bad;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;

  assign rx_s    = sync[1];
  assign exp_par = (PARITY == PARITY_ODD) ? ~(^shreg) : ^shreg;

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .soft_rst   (soft_rst),
    .start      (smp_start),
    .clr        (smp_clr),
    .run        (smp_run),
    .line       (rx_s),
    .bit_value  (bit_value),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else if (soft_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    smp_start = 1'b0;
    smp_clr   = 1'b0;
    smp_run   = 1'b1;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_adv  = 1'b0;
    word_done = 1'b0;
    frame_bad = 1'b0;
    case (state)
      ST_IDLE: begin
        smp_run = 1'b0;
        if (rx_prev && !rx_s) begin
          smp_start = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_strobe && bit_value)
          state_nxt = ST_IDLE;
        else if (bit_end)
          state_nxt = ST_DATA;
      end
      ST_DATA: begin
        shift_en = bit_strobe;
        if (bit_end && bit_idx == BW'(DATA_BITS))
          state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        par_chk = bit_strobe;
        if (bit_end)
          state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_strobe) begin
          if (!bit_value) begin
            frame_bad = 1'b1;
            smp_clr   = 1'b1;
            state_nxt = ST_BRK_WAIT;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            word_done = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
      ST_BRK_WAIT: begin
        // counter measures the current run of high line; any low sample restarts it
        if (!rx_s)
          smp_clr = 1'b1;
        else if (bit_end)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
    end else if (soft_rst) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
    end else begin
      sync    <= {sync[0], rx_in};
      rx_prev <= rx_s;
      if (smp_start) begin
        shreg    <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_flag <= 1'b0;
      end else begin
        if (shift_en) begin
          shreg   <= {bit_value, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        if (par_chk)
          par_flag <= bit_value ^ exp_par;
        if (stop_adv)
          stop_idx <= 1'b1;
      end
    end
  end

  // a handshake in the completion cycle frees the register, so the new word loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (soft_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= frame_bad;
      ovr_q  <= 1'b0;
      if (word_done) begin
        if (valid_q && !rx_if.rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shreg;
          valid_q <= 1'b1;
          perr_q  <= par_flag;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data_out = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.rx_busy     = (state != ST_IDLE);
  assign rx_if.parity_err  = perr_q;
  assign rx_if.frame_err   = ferr_q;
  assign rx_if.overrun_err = ovr_q;

endmodule
